// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state encoding and
// the default operand width.
package serial_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } seqState_e;

  localparam int DefaultWidth = 8;

endpackage : serial_add_sequencer_pkg

// File: rtl/serial_add_sequencer_full_adder.sv
// Single-bit full adder cell, time-shared by the serial adder sequencer.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic s,
  output logic cOut
);

  assign s    = a ^ b ^ cIn;
  assign cOut = (a & b) | (cIn & (a ^ b));

endmodule : FullAdder

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: feeds one operand bit pair per clock through a
// shared FullAdder, LSB first, and reports sum, carry-out and signed overflow.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cInit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             ovf
);

  localparam int CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt    = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] PreLastCnt = CntW'(WIDTH - 2);

  seqState_e        state;
  seqState_e        nextState;
  logic [CntW-1:0]  bitCnt;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] partSum;
  logic             carryReg;
  logic             carryIntoMsb;
  logic [WIDTH-1:0] sumReg;
  logic             cOutReg;
  logic             ovfReg;
  logic             busyReg;
  logic             doneReg;
  logic             faSum;
  logic             faCarry;

  FullAdder uFullAdder (
    .a    (aReg[0]),
    .b    (bReg[0]),
    .cIn  (carryReg),
    .s    (faSum),
    .cOut (faCarry)
  );

  // Next-state decode; the final bit edge moves ADD to DONE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = ADD;
        end else begin
          nextState = IDLE;
        end
      end
      ADD: begin
        if (bitCnt == LastCnt) begin
          nextState = DONE;
        end else begin
          nextState = ADD;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state   <= nextState;
      busyReg <= (nextState != IDLE);
      doneReg <= (nextState == DONE);
    end
  end

  // Operand shifters, carry recirculation and result capture.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bitCnt       <= '0;
      aReg         <= '0;
      bReg         <= '0;
      partSum      <= '0;
      carryReg     <= 1'b0;
      carryIntoMsb <= 1'b0;
      sumReg       <= '0;
      cOutReg      <= 1'b0;
      ovfReg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg     <= a;
            bReg     <= b;
            carryReg <= cInit;
            bitCnt   <= '0;
            partSum  <= '0;
          end
        end
        ADD: begin
          aReg     <= {1'b0, aReg[WIDTH-1:1]};
          bReg     <= {1'b0, bReg[WIDTH-1:1]};
          partSum  <= {faSum, partSum[WIDTH-1:1]};
          carryReg <= faCarry;
          // The carry produced by bit WIDTH-2 is the carry into the MSB.
          if (bitCnt == PreLastCnt) begin
            carryIntoMsb <= faCarry;
          end
          if (bitCnt == LastCnt) begin
            sumReg  <= {faSum, partSum[WIDTH-1:1]};
            cOutReg <= faCarry;
            ovfReg  <= carryIntoMsb ^ faCarry;
          end else begin
            bitCnt <= bitCnt + CntW'(1);
          end
        end
        DONE: begin
          bitCnt <= bitCnt;
        end
        default: begin
          bitCnt <= '0;
        end
      endcase
    end
  end

  assign busy = busyReg;
  assign done = doneReg;
  assign sum  = sumReg;
  assign cOut = cOutReg;
  assign ovf  = ovfReg;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// Directed self-checking bench for serial_add_sequencer with a cycle-level
// arithmetic reference model compared on every falling edge.
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cInit = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cOut;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  bit chkEn = 1'b0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .start (start),
    .a     (a),
    .b     (b),
    .cInit (cInit),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cOut  (cOut),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: phase counts edges since acceptance; the result is the
  // plain integer sum published WIDTH edges after the accepting edge.
  int           mPhase = 0;
  logic [W-1:0] mPendSum = '0;
  logic         mPendC = 1'b0;
  logic         mPendOvf = 1'b0;
  logic [W-1:0] mSum = '0;
  logic         mC = 1'b0;
  logic         mOvf = 1'b0;

  always @(posedge clk or negedge rstN) begin
    logic [W:0] full;
    if (!rstN) begin
      mPhase = 0;
      mPendSum = '0; mPendC = 1'b0; mPendOvf = 1'b0;
      mSum = '0; mC = 1'b0; mOvf = 1'b0;
    end else if (mPhase == 0) begin
      if (start) begin
        full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cInit};
        mPendSum = full[W-1:0];
        mPendC   = full[W];
        mPendOvf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        mPhase   = 1;
      end
    end else if (mPhase == W + 1) begin
      mPhase = 0;
    end else begin
      mPhase = mPhase + 1;
      if (mPhase == W + 1) begin
        mSum = mPendSum; mC = mPendC; mOvf = mPendOvf;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, mPhase != 0});
      chk("cyc_done", {31'd0, done}, {31'd0, mPhase == W + 1});
      chk("cyc_sum", {24'd0, sum}, {24'd0, mSum});
      chk("cyc_cout", {31'd0, cOut}, {31'd0, mC});
      chk("cyc_ovf", {31'd0, ovf}, {31'd0, mOvf});
    end
  end

  task automatic waitDone(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      failures++;
      checks++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
    end
  endtask

  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [W-1:0] eSum, input logic eC, input logic eOvf);
    int lat;
    @(negedge clk);
    a = ta; b = tb; cInit = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat);
    chk("latency", lat, W);
    chk("sum", {24'd0, sum}, {24'd0, eSum});
    chk("cout", {31'd0, cOut}, {31'd0, eC});
    chk("ovf", {31'd0, ovf}, {31'd0, eOvf});
    chk("model_sum", {24'd0, mSum}, {24'd0, eSum});
    @(negedge clk);
    chk("done_width", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int doneSeen;
    time prevT;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    chkEn = 1'b1;

    runOp(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    runOp(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    runOp(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    runOp(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Start held high through ADD: operands change but are not re-sampled.
    @(negedge clk);
    a = 8'h11; b = 8'h22; cInit = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hAA; b = 8'h55;
    waitDone(lat);
    chk("held_lat", lat, W);
    chk("held_sum", {24'd0, sum}, 32'h33);
    prevT = $time;
    @(negedge clk);
    chk("held_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("held_reaccept_busy", {31'd0, busy}, 32'd1);
    waitDone(lat);
    chk("reaccept_lat", lat, W);
    chk("reaccept_sum", {24'd0, sum}, 32'hFF);
    chk("first_period", ($time - prevT) / 10, 32'd10);
    prevT = $time;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      waitDone(lat);
      chk("period", ($time - prevT) / 10, 32'd10);
      prevT = $time;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset at edge k+4 of an in-flight operation.
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    doneSeen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    chk("no_done_after_rst", doneSeen, 32'd0);
    runOp(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_sequencer
